// File: rtl/debam_pkg.sv
// Shared types and default widths for the DeBAM product accumulator.
package debam_pkg;

   localparam int DEBAM_N     = 16;  // multiplier operand width
   localparam int DEBAM_ACC_W = 40;  // accumulator width
   localparam int DEBAM_CNT_W = 8;   // product-count width

   typedef enum logic {
      ACCUM = 1'b0,
      DONE  = 1'b1
   } debam_acc_state_t;

endpackage

// File: rtl/debam_prod_stage.sv
// S1 capture register for multiplier products: one-entry buffer that
// holds its contents while S2 is not draining it.
module debam_prod_stage #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_product,
   input  logic         in_last,
   input  logic         drain,
   output logic         s1_valid,
   output logic [W-1:0] s1_prod,
   output logic         s1_last
);

   logic accept;

   // A slot frees up either because it is empty or because S2 takes it this cycle.
   assign in_ready = !s1_valid || drain;
   assign accept   = in_valid && in_ready;

   // Occupancy flag: capture wins over drain so back-to-back products stream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         s1_valid <= 1'b0;
      else if (accept)
         s1_valid <= 1'b1;
      else if (drain)
         s1_valid <= 1'b0;
   end

   // Payload is only loaded on an accept, otherwise held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_prod <= '0;
         s1_last <= 1'b0;
      end else if (accept) begin
         s1_prod <= in_product;
         s1_last <= in_last;
      end
   end

endmodule

// File: rtl/debam_accumulator.sv
// Group accumulator behind the DeBAM multiplier. Products are registered in
// S1, summed in S2 until a 'last' marker, then the group sum / count /
// overflow flag are held on a valid/ready output.
// Build option: DEBAM_ACC_SATURATE_EN -- saturate the sum on carry-out
// instead of wrapping.
module debam_accumulator
   import debam_pkg::*;
#(
   parameter int N     = DEBAM_N,
   parameter int ACC_W = DEBAM_ACC_W,
   parameter int CNT_W = DEBAM_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   in_product,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic [CNT_W-1:0] out_count,
   output logic             out_ovf
);

   generate
      if (ACC_W < 2*N) begin : g_bad_acc_w
         $error("debam_accumulator: ACC_W must be >= 2*N");
      end
   endgenerate

   debam_acc_state_t state, state_nxt;

   logic [ACC_W-1:0] acc, acc_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             ovf, ovf_nxt;

   logic             s1_valid;
   logic [2*N-1:0]   s1_prod;
   logic             s1_last;
   logic             drain;
   logic [ACC_W:0]   sum;
   logic             carry;

   // S1 only empties into S2 while collecting a group.
   assign drain = s1_valid && (state == ACCUM);

   debam_prod_stage #(
      .W (2*N)
   ) u_prod_stage (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_product (in_product),
      .in_last    (in_last),
      .drain      (drain),
      .s1_valid   (s1_valid),
      .s1_prod    (s1_prod),
      .s1_last    (s1_last)
   );

   // One extra bit catches the carry-out of the ACC_W-bit add.
   assign sum   = {1'b0, acc} + (ACC_W+1)'(s1_prod);
   assign carry = sum[ACC_W];

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ACCUM;
      else
         state <= state_nxt;
   end

   // Next-state, accumulator update and output handshake.
   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      ovf_nxt   = ovf;
      out_valid = 1'b0;
      case (state)
         ACCUM: begin
            if (s1_valid) begin
`ifdef DEBAM_ACC_SATURATE_EN
               // Once pinned at all-ones, any further add carries again (or adds 0).
               acc_nxt = (carry || ovf) ? '1 : sum[ACC_W-1:0];
`else
               acc_nxt = sum[ACC_W-1:0];
`endif
               cnt_nxt = (&cnt) ? cnt : cnt + CNT_W'(1);
               ovf_nxt = ovf | carry;
               if (s1_last)
                  state_nxt = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               acc_nxt   = '0;
               cnt_nxt   = '0;
               ovf_nxt   = 1'b0;
               state_nxt = ACCUM;
            end
         end
         default: state_nxt = ACCUM;
      endcase
   end

   // Accumulator registers; frozen through DONE until the result is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
         ovf <= 1'b0;
      end else begin
         acc <= acc_nxt;
         cnt <= cnt_nxt;
         ovf <= ovf_nxt;
      end
   end

   assign out_acc   = acc;
   assign out_count = cnt;
   assign out_ovf   = ovf;

endmodule
